mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-002 multLoad  in  1  start request from the controller for a decoded MULT.
REQ-003 opA  in  32  multiplicand (rs value), sampled when a start is accepted.
REQ-004 opB  in  32  multiplier (rt value), sampled when a start is accepted.
REQ-005 mfReq  in  1  a MFHI/MFLO is decoded this cycle.
REQ-006 hi  out  32  upper product word, registered.
REQ-007 lo  out  32  lower product word, registered.
REQ-008 busy  out  1  multiply in progress.
REQ-009 done  out  1  one-cycle pulse when hi/lo are updated.
REQ-010 stall  out  1  PC/pipeline hold request to the datapath.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE, plus a 5-bit iteration counter cnt.
REQ-012 In IDLE with multLoad=1 at rising edge N, the module SHALL latch opA/opB, clear the 64-bit accumulator, set cnt=0 and enter RUN.
REQ-013 In RUN, each edge SHALL perform one radix-2 shift-add step (add multiplicand to upper accumulator if multiplier LSB=1, then shift right 1) and increment cnt.
REQ-014 On the edge where cnt=31 (edge N+32), the module SHALL write hi/lo from the final accumulator and enter DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE; total latency is start edge N to hi/lo valid after edge N+32.
REQ-016 busy SHALL be 1 exactly while the state is RUN.
REQ-017 stall SHALL equal busy & (mfReq | multLoad); otherwise 0.
REQ-018 multLoad while in RUN or DONE SHALL be ignored, with no operand latch and no restart.
REQ-019 hi/lo SHALL hold their value in all cycles other than the REQ-014 edge; a new MULT overwrites both.
REQ-020 Accumulator arithmetic SHALL be 33-bit on the upper half so the carry is kept; the result is the exact 64-bit product, with no overflow flag.
REQ-021 multLoad in DONE SHALL be ignored; the controller re-issues it after stall drops.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, cnt=0, accumulator=0, hi=0, lo=0, busy=0, done=0, stall=0, regardless of clk.
REQ-023 Reset during RUN SHALL abort the operation, leave hi/lo at 0, and produce no done pulse.
REQ-024 The first multLoad after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro MULT_SIGNED_EN SHALL select the signedness of the multiply.
REQ-026 With MULT_SIGNED_EN defined, the module SHALL latch |opA| and |opB|, record sign = opA[31]^opB[31], and two's-complement-negate the 64-bit result on the REQ-014 edge when sign=1, with no added latency.
REQ-027 Without MULT_SIGNED_EN, operands SHALL be treated as unsigned and no sign logic is synthesized.

Structure
REQ-028 The FSM state encoding, ITER_COUNT=32, and the FUNC_MULT/FUNC_MFHI/FUNC_MFLO codes SHALL live in the shared constants package used by controller.
REQ-029 One sub-module, mult_datapath, SHALL hold the operand registers, accumulator and shift-add adder; mult_sequencer holds the FSM, counter, sign logic and hi/lo registers.
REQ-030 hi/lo SHALL feed the regWriteDataSrc 01 (LO) and 10 (HI) mux inputs unchanged.

Verification
REQ-031 opA=3, opB=5, multLoad at edge N -> busy over edges N..N+31, done after edge N+32, hi=0, lo=15.
REQ-032 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; with MULT_SIGNED_EN -> hi=0, lo=1.
REQ-033 With MULT_SIGNED_EN, opA=0xFFFFFFFE (-2) and opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2.
REQ-034 mfReq=1 during RUN -> stall=1 each cycle until DONE; second multLoad at N+5 -> ignored, result still that of the first operands.
REQ-035 rst pulsed at N+10 mid-RUN -> hi=lo=0, busy=0 at once, no done; new multLoad of 2*2 -> lo=4 after 32 edges.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_sequencer_pkg                                         |
// | Purpose : Constants shared by the multiply sequencer and the         |
// |           controller: the FSM state encoding, the iteration count,   |
// |           the R-type funct codes for MULT/MFHI/MFLO, the             |
// |           regWriteDataSrc codes, and a helper for absolute values.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package mult_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  localparam int ITER_COUNT = 32;

  // R-type funct field codes decoded by the controller
  localparam logic [5:0] FUNC_MULT = 6'h18;
  localparam logic [5:0] FUNC_MFHI = 6'h10;
  localparam logic [5:0] FUNC_MFLO = 6'h12;

  // regWriteDataSrc mux codes fed directly by lo/hi
  localparam logic [1:0] REGSRC_LO = 2'b01;
  localparam logic [1:0] REGSRC_HI = 2'b10;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_datapath                                              |
// | Purpose : Operand registers, 64-bit accumulator and the 33-bit       |
// |           shift-add adder of the radix-2 multiplier.                 |
// | Ports   : clk, rst      - clock, async active-high reset             |
// |           load          - latch operands, clear accumulator          |
// |           step          - perform one shift-add iteration            |
// |           mcand_in[31:0]- multiplicand to latch                      |
// |           mplr_in[31:0] - multiplier to latch                        |
// |           acc_next[63:0]- accumulator value after the current step   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mult_datapath
  import mult_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplr_in,
  output logic [63:0] acc_next
);

  logic [31:0] mcand;
  logic [31:0] mplr;
  logic [63:0] acc;
  logic [32:0] upper_sum;

  // Adding into the upper half with a 33rd bit keeps the carry, which
  // the right shift then moves back into bit 63.
  always_comb begin
    upper_sum = {1'b0, acc[63:32]} + {1'b0, (mplr[0] ? mcand : 32'd0)};
    acc_next  = {upper_sum, acc[31:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      acc   <= '0;
    end else if (step) begin
      acc  <= acc_next;
      mplr <= {1'b0, mplr[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_sequencer                                             |
// | Purpose : Multi-cycle 32x32->64 multiply unit with HI/LO registers   |
// |           and pipeline stall generation. 32 shift-add iterations;    |
// |           hi/lo valid after start edge N+32, done pulses one cycle.  |
// | Ports   : clk, rst       - clock, async active-high reset            |
// |           multLoad       - start request for a decoded MULT          |
// |           opA, opB[31:0] - multiplicand / multiplier                 |
// |           mfReq          - MFHI/MFLO decoded this cycle              |
// |           hi, lo[31:0]   - registered product words                  |
// |           busy           - multiply in progress (state RUN)          |
// |           done           - one-cycle pulse after hi/lo update        |
// |           stall          - pipeline hold request                     |
// | Config  : MULT_SIGNED_EN - when defined, signed (two's-complement)   |
// |           multiply; otherwise unsigned with no sign logic.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mult_sequencer
  import mult_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        multLoad,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        mfReq,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  mult_state_t state;
  mult_state_t state_next;
  logic [4:0]  cnt;
  logic        start;
  logic        last_iter;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_next;
  logic [63:0] product;

  assign start     = (state == ST_IDLE) && multLoad;
  assign last_iter = (state == ST_RUN) && (cnt == 5'(ITER_COUNT - 1));

`ifdef MULT_SIGNED_EN
  logic sign;

  assign a_mag = abs32(opA);
  assign b_mag = abs32(opB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign <= 1'b0;
    end else if (start) begin
      sign <= opA[31] ^ opB[31];
    end
  end

  // Negation happens on the same edge as the final step, so signed mode
  // adds no latency.
  assign product = sign ? (~acc_next + 64'd1) : acc_next;
`else
  assign a_mag   = opA;
  assign b_mag   = opB;
  assign product = acc_next;
`endif

  mult_datapath u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .step     (state == ST_RUN),
    .mcand_in (a_mag),
    .mplr_in  (b_mag),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (multLoad) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    stall = busy & (mfReq | multLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 5'd1;
      end
      if (last_iter) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
    end
  end

endmodule
`default_nettype wire
